// File: rtl/partial_product_accumulator.sv
// Shift-and-accumulate stage after the Karatsuba partial-product adder.
// Places each tagged sum at its word offset and emits the finished product.
module partial_product_accumulator #(
    parameter  int FSIZE           = 32,
    parameter  int PRIMITIVE_COUNT = 4,
    parameter  int RES_WORDS       = 4,
    localparam int AW              = FSIZE*2 + $clog2(PRIMITIVE_COUNT),
    localparam int RW              = RES_WORDS*FSIZE,
    localparam int SW              = $clog2(RES_WORDS)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_data,
    input  logic [SW-1:0] in_shift,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_data,
    output logic          out_ovf,
    output logic [7:0]    out_beats
);

    // Wide enough for the largest encodable shift, even past RES_WORDS
    localparam int EW = AW + (2**SW)*FSIZE;

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [RW-1:0] r_acc;
    logic          r_ovf_acc;
    logic [7:0]    r_cnt;
    logic [RW-1:0] r_out_data;
    logic          r_out_ovf;
    logic [7:0]    r_out_beats;

    logic [EW-1:0] w_term;
    logic [RW:0]   w_sum;
    logic          w_lost;
    logic          w_fire;
    logic [RW-1:0] w_acc_nxt;
    logic          w_ovf_nxt;
    logic [7:0]    w_cnt_nxt;

    assign w_term    = EW'(in_data) << (32'(in_shift) * FSIZE);
    assign w_lost    = |w_term[EW-1:RW];
    assign w_sum     = {1'b0, r_acc} + {1'b0, w_term[RW-1:0]};
    assign w_fire    = in_valid && in_ready;
    assign w_acc_nxt = w_sum[RW-1:0];
    assign w_ovf_nxt = r_ovf_acc | w_sum[RW] | w_lost;
    assign w_cnt_nxt = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_ACC: begin
                if (w_fire && in_last) w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready && !(w_fire && in_last)) w_state_nxt = ST_ACC;
            end
            default: w_state_nxt = ST_ACC;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        unique case (r_state)
            ST_ACC: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
            end
        endcase
    end

    // acc is cleared when a product completes, so beats taken in OUT start fresh
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_acc       <= '0;
            r_ovf_acc   <= 1'b0;
            r_cnt       <= 8'd0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
            r_out_beats <= 8'd0;
        end else if (w_fire) begin
            if (in_last) begin
                r_out_data  <= w_acc_nxt;
                r_out_ovf   <= w_ovf_nxt;
                r_out_beats <= w_cnt_nxt;
                r_acc       <= '0;
                r_ovf_acc   <= 1'b0;
                r_cnt       <= 8'd0;
            end else begin
                r_acc       <= w_acc_nxt;
                r_ovf_acc   <= w_ovf_nxt;
                r_cnt       <= w_cnt_nxt;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;
    assign out_beats = r_out_beats;

endmodule

// File: tb/tb_partial_product_accumulator.sv
// Bench for partial_product_accumulator: directed scenarios plus random
// traffic against a wide-arithmetic product model.
module tb_partial_product_accumulator;

    localparam int AW = 66;
    localparam int RW = 128;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_data = '0;
    logic [SW-1:0] in_shift = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] out_data;
    logic          out_ovf;
    logic [7:0]    out_beats;

    int checks = 0;
    int failures = 0;

    // Model: exact (unbounded-enough) running sum of the current product
    logic [511:0] m_sum;
    int           m_n;
    logic         m_valid;
    logic [127:0] m_data;
    logic         m_ovf;
    logic [7:0]   m_beats;

    partial_product_accumulator #(
        .FSIZE(32),
        .PRIMITIVE_COUNT(4),
        .RES_WORDS(4)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_shift(in_shift),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_ovf(out_ovf),
        .out_beats(out_beats)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_sum   = '0;
        m_n     = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_ovf   = 1'b0;
        m_beats = 8'd0;
    endtask

    // One clock: drive, check at negedge, then advance the model at posedge
    task automatic cyc(bit v, logic [AW-1:0] d, logic [SW-1:0] s,
                       bit l, bit ordy);
        bit rdy;
        in_valid  = v;
        in_data   = d;
        in_shift  = s;
        in_last   = l;
        out_ready = ordy;
        @(negedge clk);
        rdy = !m_valid || ordy;
        check("in_ready", 128'(in_ready), 128'(rdy));
        check("out_valid", 128'(out_valid), 128'(m_valid));
        check("out_data", out_data, m_data);
        check("out_ovf", 128'(out_ovf), 128'(m_ovf));
        check("out_beats", 128'(out_beats), 128'(m_beats));
        @(posedge clk);
        if (!rstn) begin
            model_clear();
        end else begin
            if (m_valid && ordy) m_valid = 1'b0;
            if (v && rdy) begin
                m_sum = m_sum + (512'(d) << (32 * int'(s)));
                m_n++;
                if (l) begin
                    m_data  = m_sum[127:0];
                    m_ovf   = |m_sum[511:128];
                    m_beats = (m_n > 255) ? 8'd255 : 8'(m_n);
                    m_valid = 1'b1;
                    m_sum   = '0;
                    m_n     = 0;
                end
            end
        end
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, 1);
    endtask

    initial begin
        bit            hv;
        logic [AW-1:0] hd;
        logic [SW-1:0] hs;
        bit            hl;
        bit            ordy;
        bit            took;

        model_clear();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(1);

        // Four-beat product
        cyc(1, 66'h1, 2'd0, 0, 1);
        cyc(1, 66'h2, 2'd1, 0, 1);
        cyc(1, 66'h3, 2'd2, 0, 1);
        cyc(1, 66'h4, 2'd3, 1, 1);
        check("four_data", out_data, 128'h00000004_00000003_00000002_00000001);
        check("four_beats", 128'(out_beats), 128'd4);
        check("four_valid", 128'(out_valid), 128'd1);
        idle(1);

        // Carry / shifted-out overflow
        cyc(1, {AW{1'b1}}, 2'd3, 0, 1);
        cyc(1, 66'h1 << 64, 2'd0, 1, 1);
        check("ovf_flag", 128'(out_ovf), 128'd1);
        check("ovf_data", out_data, 128'hFFFFFFFF_00000001_00000000_00000000);
        idle(1);

        // Backpressure: held result, stalled new beat
        cyc(1, 66'h7, 2'd2, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 66'h9, 2'd0, 0, 0);
        check("bp_hold", out_data, 128'h7 << 64);
        cyc(1, 66'h9, 2'd0, 0, 1);
        cyc(1, 66'h1, 2'd1, 1, 1);
        check("bp_next", out_data, 128'h1_00000009);
        check("bp_beats", 128'(out_beats), 128'd2);
        idle(1);

        // Back-to-back single-beat products
        cyc(1, 66'd5, 2'd0, 1, 1);
        check("b2b_5", out_data, 128'd5);
        cyc(1, 66'd6, 2'd0, 1, 1);
        check("b2b_6", out_data, 128'd6);
        check("b2b_v", 128'(out_valid), 128'd1);
        cyc(1, 66'd7, 2'd0, 1, 1);
        check("b2b_7", out_data, 128'd7);
        check("b2b_n", 128'(out_beats), 128'd1);
        idle(1);

        // Reset mid-product; the beat on the reset edge must be dropped
        cyc(1, 66'h10, 2'd0, 0, 1);
        cyc(1, 66'h10, 2'd0, 0, 1);
        rstn = 1'b0;
        cyc(1, 66'h77, 2'd0, 1, 1);
        rstn = 1'b1;
        check("rst_data", out_data, 128'd0);
        check("rst_valid", 128'(out_valid), 128'd0);
        cyc(1, 66'h3, 2'd0, 1, 1);
        check("rst_after", out_data, 128'd3);
        check("rst_beats", 128'(out_beats), 128'd1);
        idle(1);

        // Beat counter saturation
        for (int i = 0; i < 300; i++) cyc(1, 66'h1, 2'd0, 0, 1);
        cyc(1, 66'h1, 2'd0, 1, 1);
        check("sat_beats", 128'(out_beats), 128'd255);
        check("sat_data", out_data, 128'd301);
        idle(1);

        // Random traffic; inputs held while a beat is stalled
        hv = 0;
        hd = '0;
        hs = '0;
        hl = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!hv) begin
                hv = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 1) == 1)
                    hd = AW'({$urandom, $urandom, $urandom});
                else
                    hd = AW'($urandom_range(0, 15));
                hs = SW'($urandom);
                hl = ($urandom_range(0, 3) == 0);
            end
            ordy = ($urandom_range(0, 3) != 0);
            took = hv && (!m_valid || ordy);
            cyc(hv, hd, hs, hl, ordy);
            if (took) hv = 0;
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/partial_product_accumulator.md
# partial_product_accumulator

Shift-and-accumulate stage directly downstream of the partial-product adder in the Karatsuba datapath. It consumes the adder's stream of `FSIZE*2+$clog2(PRIMITIVE_COUNT)`-bit sums, each tagged with a word offset. It places each sum at `in_shift*FSIZE` bits and accumulates into a `RES_WORDS*FSIZE`-bit result. On the beat marked last, it emits the completed product through a valid/ready output register.

## Interface
- `FSIZE`, 32, primitive operand width in bits
- `PRIMITIVE_COUNT`, 4, number of primitives summed by the upstream adder; `AW = FSIZE*2+$clog2(PRIMITIVE_COUNT)` is the input width
- `RES_WORDS`, 4, result width in `FSIZE` words; `RW = RES_WORDS*FSIZE`; `SW = $clog2(RES_WORDS)`
- `clk` input 1: single clock, all state on the rising edge
- `rstn` input 1: reset, synchronous and active-low
- `in_valid` input 1: input beat valid
- `in_ready` output 1: input beat accepted when `in_valid && in_ready`
- `in_data` input AW: partial sum from the adder
- `in_shift` input SW: word offset; the beat is weighted by `2^(in_shift*FSIZE)`
- `in_last` input 1: final beat of the current product
- `out_valid` output 1: result register holds a completed product
- `out_ready` input 1: consumer takes the result when `out_valid && out_ready`
- `out_data` output RW: completed product, modulo `2^RW`
- `out_ovf` output 1: product lost bits (carry or shifted-out bits)
- `out_beats` output 8: number of beats in the product, saturating at 255

## Operation
- State machine with two states.
  - ACC: collecting beats; `out_valid=0`.
  - OUT: result held; `out_valid=1`.
- Accumulator state:
  - `acc` is RW bits.
  - `ovf_acc` is 1 bit, sticky.
  - `cnt` is 8 bits, saturating.
- Accepted beat:
  - The term is `in_data` zero-extended and shifted left by `in_shift*FSIZE`.
  - Term bits at or above RW are discarded. If any discarded bit is nonzero, set `ovf_acc`.
  - Update `acc <= acc + term[RW-1:0]`. A carry out of bit RW-1 sets `ovf_acc`.
  - Update `cnt <= min(cnt+1, 255)`.
- Accepted beat with `in_last=1`:
  - Load `out_data` with the updated acc value that includes this beat; load `out_ovf` and `out_beats` the same way.
  - Clear `acc`, `ovf_acc` and `cnt` to 0.
  - Go to OUT.
- `in_ready`:
  - 1 in ACC.
  - In OUT, `in_ready = out_ready`.
  - Combinational from `out_ready`; no combinational path from `in_valid`.
- In OUT with `out_ready=1`:
  - The result is consumed.
  - If no last beat is accepted that cycle, go to ACC.
  - A non-last beat accepted in the same cycle accumulates into the already-cleared acc.
  - A last beat accepted in the same cycle reloads the output registers and stays in OUT (back-to-back products).
- Single-beat product (`in_last=1` on the first beat) is legal: `out_beats=1`.
- `in_shift >= RES_WORDS` cannot occur when RES_WORDS is a power of 2. Otherwise such a term shifts out entirely: it sets `ovf_acc` if `in_data != 0`, and otherwise adds nothing.
- Output registers do not change while `out_valid && !out_ready`.

## Timing
- Reset (`rstn=0` at a rising edge):
  - State goes to ACC.
  - `acc`, `ovf_acc`, `cnt` clear to 0.
  - Outputs: `out_valid=0`, `out_data=0`, `out_ovf=0`, `out_beats=0`, `in_ready=1` from the next cycle.
- Reset mid-product or mid-hold discards all partial and held results. No beat is accepted on a reset edge.
- Latency: a last beat accepted at edge t gives `out_valid=1` after edge t, for a full pipeline throughput of one beat per cycle.
- While `out_ready` stays 1, one product may complete every cycle, with no bubble.
- Upstream must hold `in_*` stable while `in_valid && !in_ready`. Downstream sees `out_*` stable while `out_valid && !out_ready`.

## Test plan
- **Four-beat product** (FSIZE=32, RES_WORDS=4). Beats (data, shift):
  - (0x1, 0)
  - (0x2, 1)
  - (0x3, 2)
  - (0x4, 3), last

  Required: `out_data = 0x00000004_00000003_00000002_00000001`, `out_ovf=0`, `out_beats=4`, `out_valid` one cycle after the last beat.
- **Carry overflow.** Beats:
  - (2^66-1, 3)
  - (2^64, 0), last

  Required: `out_ovf=1`, `out_data` equal to the truncated modulo-2^128 sum.
- **Backpressure.** Complete a product with `out_ready=0` for 5 cycles while `in_valid=1` with a new beat.
  - Required: `in_ready=0` and `out_data` stable for those 5 cycles.
  - When `out_ready` rises, the new beat is accepted in the same cycle. The next result excludes the old product's beats.
- **Back-to-back single-beat products** with `out_ready=1`. Inputs: data 5, 6, 7, all with `in_last=1` and shift 0.
  - Required: `out_data` = 5, 6, 7 on consecutive cycles, `out_beats=1` each, `out_valid` continuously 1.
- **Reset mid-product.** Two beats of value 0x10 accepted, then `rstn=0` for one cycle, then a single last beat of 0x3.
  - Required: all outputs 0 after reset, then `out_data=0x3`, `out_beats=1`.
- **Beat counter saturation.** 300 beats of (0x1, 0), then a last beat.
  - Required: `out_beats=255`, `out_data=301`.
